// File: rtl/cpu_core.sv
// cpu_core: single-cycle 16-bit-instruction CPU with program download port,
// 8x32 register file, NZCV flags, data RAM and one memory-mapped GPIO byte.
// Ports:
//   clk                clock, all state changes on its rising edge
//   rst_n              asynchronous active-low reset of CPU state
//   download_program   1 = write program memory and hold execution
//   instruction_index  halfword index written during download
//   program_in         instruction written during download
//   gpio_state         registered GPIO output byte
module cpu_core #(
    parameter int PROG_WORDS = 64,
    parameter int DATA_WORDS = 16,
    parameter int START_PC   = 10,
    parameter int GPIO_ADDR  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        download_program,
    input  logic [31:0] instruction_index,
    input  logic [15:0] program_in,
    output logic [7:0]  gpio_state
);

    localparam int PAW = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;
    localparam int DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [31:0] P_WORDS = 32'(PROG_WORDS);
    localparam logic [31:0] D_WORDS = 32'(DATA_WORDS);
    localparam logic [31:0] START   = 32'(START_PC);
    localparam logic [31:0] GPIO    = 32'(GPIO_ADDR);

    logic [15:0] prog_mem [PROG_WORDS];
    logic [31:0] dmem [DATA_WORDS];
    logic [31:0] regs [8];
    logic [31:0] pc;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;

    logic [15:0] instr;
    logic [31:0] rd_val;
    logic [31:0] rm_val;
    logic [31:0] rn_val;
    logic [31:0] rt_val;
    logic [31:0] imm8;
    logic [31:0] addr;
    logic        addr_gpio;
    logic        addr_ok;
    logic [31:0] ld_data;
    logic [35:0] imm_as;
    logic [35:0] reg_cmp;

    logic [31:0] pc_nxt;
    logic        rf_we;
    logic [2:0]  rf_idx;
    logic [31:0] rf_data;
    logic [3:0]  nzcv_nxt;
    logic        dm_we;
    logic        gpio_we;

    // Returns {N, Z, C, V, result}; C is carry out, or NOT borrow on subtract.
    function automatic logic [35:0] addsub(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sub
    );
        logic [31:0] bx;
        logic [32:0] s;
        logic        v;
        bx = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bx} + {32'd0, sub};
        v  = (a[31] == bx[31]) && (s[31] != a[31]);
        return {s[31], s[31:0] == 32'd0, s[32], v, s[31:0]};
    endfunction

    function automatic logic cond_pass(
        input logic [3:0] cc,
        input logic       n,
        input logic       z,
        input logic       c,
        input logic       v
    );
        logic t;
        case (cc)
            4'h0:    t = z;
            4'h1:    t = !z;
            4'h2:    t = c;
            4'h3:    t = !c;
            4'h4:    t = n;
            4'h5:    t = !n;
            4'h6:    t = v;
            4'h7:    t = !v;
            4'h8:    t = c && !z;
            4'h9:    t = !c || z;
            4'hA:    t = n == v;
            4'hB:    t = n != v;
            4'hC:    t = !z && (n == v);
            4'hD:    t = z || (n != v);
            4'hE:    t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Program writes are independent of reset so a download during reset lands.
    always_ff @(posedge clk) begin
        if (download_program && (instruction_index < P_WORDS))
            prog_mem[instruction_index[PAW-1:0]] <= program_in;
    end

    assign instr  = (pc < P_WORDS) ? prog_mem[pc[PAW-1:0]] : 16'h0000;
    assign rd_val = regs[instr[10:8]];
    assign rm_val = regs[instr[5:3]];
    assign rn_val = regs[instr[5:3]];
    assign rt_val = regs[instr[2:0]];
    assign imm8   = {24'd0, instr[7:0]};

    assign addr      = rn_val + {25'd0, instr[10:6], 2'b00};
    assign addr_gpio = addr == GPIO;
    assign addr_ok   = {2'b00, addr[31:2]} < D_WORDS;

    always_comb begin
        ld_data = 32'd0;
        if (addr_gpio)
            ld_data = {24'd0, gpio_state};
        else if (addr_ok)
            ld_data = dmem[addr[DAW+1:2]];
    end

    assign imm_as  = addsub(rd_val, imm8, instr[12:11] != 2'b10);
    assign reg_cmp = addsub(regs[instr[2:0]], rm_val, 1'b1);

    always_comb begin
        pc_nxt   = pc + 32'd1;
        rf_we    = 1'b0;
        rf_idx   = instr[2:0];
        rf_data  = 32'd0;
        nzcv_nxt = {flag_n, flag_z, flag_c, flag_v};
        dm_we    = 1'b0;
        gpio_we  = 1'b0;
        unique case (1'b1)
            instr[15:13] == 3'b001: begin
                rf_idx = instr[10:8];
                case (instr[12:11])
                    2'b00: begin
                        rf_we       = 1'b1;
                        rf_data     = imm8;
                        nzcv_nxt[3] = 1'b0;
                        nzcv_nxt[2] = imm8 == 32'd0;
                    end
                    2'b01: begin
                        nzcv_nxt = imm_as[35:32];
                    end
                    default: begin
                        rf_we    = 1'b1;
                        rf_data  = imm_as[31:0];
                        nzcv_nxt = imm_as[35:32];
                    end
                endcase
            end
            instr[15:10] == 6'b010000: begin
                case (instr[9:6])
                    4'b0000: begin
                        rf_we   = 1'b1;
                        rf_data = regs[instr[2:0]] & rm_val;
                    end
                    4'b0001: begin
                        rf_we   = 1'b1;
                        rf_data = regs[instr[2:0]] ^ rm_val;
                    end
                    4'b1100: begin
                        rf_we   = 1'b1;
                        rf_data = regs[instr[2:0]] | rm_val;
                    end
                    4'b1111: begin
                        rf_we   = 1'b1;
                        rf_data = ~rm_val;
                    end
                    default: ;
                endcase
                if (rf_we) begin
                    nzcv_nxt[3] = rf_data[31];
                    nzcv_nxt[2] = rf_data == 32'd0;
                end
                if (instr[9:6] == 4'b1010)
                    nzcv_nxt = reg_cmp[35:32];
            end
            instr[15:12] == 4'b0110: begin
                if (instr[11]) begin
                    rf_we   = 1'b1;
                    rf_data = ld_data;
                end else if (addr_gpio) begin
                    gpio_we = 1'b1;
                end else begin
                    dm_we = addr_ok;
                end
            end
            instr[15:12] == 4'b1101: begin
                if (cond_pass(instr[11:8], flag_n, flag_z, flag_c, flag_v))
                    pc_nxt = pc + 32'd2 + {{24{instr[7]}}, instr[7:0]};
            end
            instr[15:11] == 5'b11100: begin
                pc_nxt = pc + 32'd2 + {{21{instr[10]}}, instr[10:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= START;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            gpio_state <= 8'd0;
            for (int i = 0; i < 8; i++)
                regs[i] <= 32'd0;
        end else if (download_program) begin
            pc <= START;
        end else begin
            pc <= pc_nxt;
            {flag_n, flag_z, flag_c, flag_v} <= nzcv_nxt;
            if (rf_we)
                regs[rf_idx] <= rf_data;
            if (gpio_we)
                gpio_state <= rt_val[7:0];
            if (dm_we)
                dmem[addr[DAW+1:2]] <= rt_val;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed bench for cpu_core with a GPIO event scoreboard.
// Checks reset, download, the countdown loop, ALU/flags, memory and branches.
module tb_cpu_core;

    logic        clk;
    logic        rst_n;
    logic        download_program;
    logic [31:0] instruction_index;
    logic [15:0] program_in;
    logic [7:0]  gpio_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } ev_t;

    ev_t q[$];

    logic [15:0] prog1 [8] = '{
        16'h2120, 16'h2005, 16'h6008, 16'h3801,
        16'h2800, 16'hD1FB, 16'hE7FE, 16'h4002
    };

    logic [15:0] prog2 [23] = '{
        16'h23FF, 16'h3301, 16'h429B, 16'h2120,
        16'h26A5, 16'h600E, 16'h205A, 16'h6068,
        16'h6028, 16'h620E, 16'h686C, 16'h680F,
        16'h682A, 16'h6A0B, 16'h43F5, 16'h4070,
        16'h4331, 16'h3EA6, 16'hD401, 16'h2201,
        16'h2202, 16'hD205, 16'hE7FE
    };

    cpu_core dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .download_program  (download_program),
        .instruction_index (instruction_index),
        .program_in        (program_in),
        .gpio_state        (gpio_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dl(input logic [31:0] idx, input logic [15:0] val);
        download_program  = 1'b1;
        instruction_index = idx;
        program_in        = val;
        tick();
    endtask

    // Countdown loop: STR at cycle 3, then every 4 cycles, values 5..1.
    task automatic sb_run();
        int         cyc;
        logic [7:0] last;
        ev_t        e;
        cyc  = 0;
        last = gpio_state;
        for (int k = 0; k < 5; k++) begin
            e.val = 8'(5 - k);
            e.cyc = 3 + 4 * k;
            q.push_back(e);
        end
        while (q.size() > 0 && cyc < 40) begin
            tick();
            cyc++;
            if (gpio_state !== last) begin
                e = q.pop_front();
                check("gpio_val", {24'd0, gpio_state}, {24'd0, e.val});
                check("gpio_cyc", cyc, e.cyc);
                last = gpio_state;
            end
        end
        check("sb_drain", q.size(), 0);
        q.delete();
    endtask

    initial begin
        rst_n             = 1'b0;
        download_program  = 1'b0;
        instruction_index = 32'd0;
        program_in        = 16'h0000;
        tick();
        tick();
        check("rst_pc", dut.pc, 32'd10);
        check("rst_gpio", {24'd0, gpio_state}, 32'd0);
        check("rst_r0", dut.regs[0], 32'd0);
        check("rst_flags",
              {28'd0, dut.flag_n, dut.flag_z, dut.flag_c, dut.flag_v},
              32'd0);
        rst_n = 1'b1;

        dl(32'd40, 16'h1234);
        dl(32'd1000, 16'hBEEF);
        check("oob_dl_mem", {16'd0, dut.prog_mem[40]}, 32'h1234);
        check("dl_pc_hold", dut.pc, 32'd10);

        for (int i = 0; i < 8; i++)
            dl(32'(10 + i), prog1[i]);
        check("dl_gpio_hold", {24'd0, gpio_state}, 32'd0);

        download_program = 1'b0;
        sb_run();
        repeat (8) tick();
        check("loop_gpio", {24'd0, gpio_state}, 32'd1);
        check("loop_pc", dut.pc, 32'd16);
        check("loop_r0", dut.regs[0], 32'd0);
        check("loop_r2", dut.regs[2], 32'd0);

        download_program  = 1'b1;
        instruction_index = 32'd50;
        program_in        = 16'h0000;
        repeat (3) tick();
        check("hold_pc", dut.pc, 32'd10);
        check("hold_gpio", {24'd0, gpio_state}, 32'd1);
        check("hold_r1", dut.regs[1], 32'd32);
        download_program = 1'b0;
        repeat (12) tick();
        check("mid_gpio", {24'd0, gpio_state}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_gpio", {24'd0, gpio_state}, 32'd0);
        check("async_pc", dut.pc, 32'd10);
        check("async_r1", dut.regs[1], 32'd0);
        #1;
        rst_n = 1'b1;
        sb_run();

        rst_n = 1'b0;
        for (int i = 0; i < 23; i++)
            dl(32'(10 + i), prog2[i]);
        check("rstdl_pc", dut.pc, 32'd10);
        check("rstdl_r3", dut.regs[3], 32'd0);
        rst_n            = 1'b1;
        download_program = 1'b0;
        tick();
        tick();
        check("add_r3", dut.regs[3], 32'd256);
        check("add_flags",
              {28'd0, dut.flag_n, dut.flag_z, dut.flag_c, dut.flag_v},
              32'h0);
        tick();
        check("cmp_flags",
              {28'd0, dut.flag_n, dut.flag_z, dut.flag_c, dut.flag_v},
              32'h6);
        repeat (22) tick();
        check("p2_gpio", {24'd0, gpio_state}, 32'hA5);
        check("ldr_ram", dut.regs[4], 32'h5A);
        check("ldr_gpio", dut.regs[7], 32'hA5);
        check("oob_str", dut.regs[2], 32'h5A);
        check("oob_ldr", dut.regs[3], 32'd0);
        check("mvn", dut.regs[5], 32'hFFFFFF5A);
        check("eor", dut.regs[0], 32'hFF);
        check("orr", dut.regs[1], 32'hA5);
        check("sub_neg", dut.regs[6], 32'hFFFFFFFF);
        check("br_pc", dut.pc, 32'd32);
        check("sub_flags",
              {28'd0, dut.flag_n, dut.flag_z, dut.flag_c, dut.flag_v},
              32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
